// File: rtl/des_pkg.sv
// Shared constants, tables and FSM state type for the DES subkey generator.
package des_pkg;

  localparam int unsigned NUM_ROUNDS = 16;
  localparam int unsigned KEY_W      = 64;
  localparam int unsigned CD_W       = 56;
  localparam int unsigned HALF_W     = 28;
  localparam int unsigned SK_W       = 48;
  localparam int unsigned ROUND_W    = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Left-rotate amount applied to C/D before round n (index n-1)
  localparam logic [1:0] SHIFT_TAB [NUM_ROUNDS] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // FIPS 46-3 PC-1: output bit i+1 takes key bit PC1_TAB[i] (bit 1 = MSB)
  localparam int unsigned PC1_TAB [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // FIPS 46-3 PC-2: output bit i+1 takes CD bit PC2_TAB[i] (bit 1 = MSB)
  localparam int unsigned PC2_TAB [SK_W] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

endpackage

// File: rtl/pc2.sv
// PC-2 compression permutation: 56-bit C||D to 48-bit round subkey.
// Vectors are descending, so FIPS bit j lives at index (width+1-j).
module pc2
  import des_pkg::*;
(
  input  logic [CD_W:1] i_cd,
  output logic [SK_W:1] o_sk
);

  // Pure wiring, one output bit per table entry
  for (genvar g = 0; g < int'(SK_W); g++) begin : g_pc2
    assign o_sk[SK_W-g] = i_cd[CD_W+1-PC2_TAB[g]];
  end

endmodule

// File: rtl/des_subkey_gen.sv
// DES key schedule: accepts a 64-bit key and streams the 16 round subkeys
// in encrypt (K1..K16) or decrypt (K16..K1) order over a valid/ready port.
module des_subkey_gen
  import des_pkg::*;
#(
  parameter bit DEFAULT_DECRYPT = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_W:1]     key,
  input  logic               decrypt,
  input  logic               key_valid,
  output logic               key_ready,
  output logic [SK_W:1]      sk,
  output logic [ROUND_W-1:0] sk_round,
  output logic               sk_valid,
  input  logic               sk_ready,
  output logic               busy
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [HALF_W:1]      r_c;
  logic [HALF_W:1]      r_d;
  logic [HALF_W:1]      w_c_base;
  logic [HALF_W:1]      w_d_base;
  logic [HALF_W:1]      w_c_nxt;
  logic [HALF_W:1]      w_d_nxt;
  logic [CD_W:1]        w_pc1;
  logic [SK_W:1]        r_sk;
  logic [SK_W:1]        w_sk_pc2;
  logic [ROUND_W-1:0]   r_round;
  logic [ROUND_W-1:0]   w_round_nxt;
  logic                 r_dec;
  logic                 w_dec_nxt;
  logic                 w_sk_upd;
  logic                 w_rotl;
  logic [1:0]           w_shift;
  logic                 w_last;
  logic                 w_unused_parity;

  // PC-1 on the raw key; only consumed in the load cycle
  for (genvar g = 0; g < int'(CD_W); g++) begin : g_pc1
    assign w_pc1[CD_W-g] = key[KEY_W+1-PC1_TAB[g]];
  end

  // Parity bits (FIPS 8,16,...,64) intentionally drop out of the schedule
  assign w_unused_parity = ^{key[57], key[49], key[41], key[33],
                             key[25], key[17], key[9],  key[1]};

  assign w_last = r_dec ? (r_round == ROUND_W'(0)) : (r_round == ROUND_W'(NUM_ROUNDS - 1));

  // Next-state, C/D update and round bookkeeping
  always_comb begin
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    w_dec_nxt   = r_dec;
    w_sk_upd    = 1'b0;
    w_c_base    = r_c;
    w_d_base    = r_d;
    w_shift     = 2'd0;
    w_rotl      = 1'b1;

    unique case (r_state)
      ST_IDLE: begin
        if (key_valid) begin
          w_state_nxt = ST_RUN;
          w_dec_nxt   = decrypt;
          w_sk_upd    = 1'b1;
          w_c_base    = w_pc1[CD_W:HALF_W+1];
          w_d_base    = w_pc1[HALF_W:1];
          if (decrypt) begin
            // K16 comes straight from C0/D0 since C16 == C0
            w_round_nxt = ROUND_W'(NUM_ROUNDS - 1);
          end else begin
            w_shift     = SHIFT_TAB[0];
            w_round_nxt = ROUND_W'(0);
          end
        end
      end
      ST_RUN: begin
        if (sk_ready) begin
          if (w_last) begin
            w_state_nxt = ST_IDLE;
          end else if (r_dec) begin
            w_sk_upd    = 1'b1;
            w_rotl      = 1'b0;
            w_shift     = SHIFT_TAB[r_round];
            w_round_nxt = ROUND_W'(r_round - ROUND_W'(1));
          end else begin
            w_sk_upd    = 1'b1;
            w_shift     = SHIFT_TAB[ROUND_W'(r_round + ROUND_W'(1))];
            w_round_nxt = ROUND_W'(r_round + ROUND_W'(1));
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Rotations toward the MSB (FIPS bit 1) for encrypt, away for decrypt
    if (w_shift == 2'd1) begin
      w_c_nxt = w_rotl ? {w_c_base[HALF_W-1:1], w_c_base[HALF_W]}
                       : {w_c_base[1], w_c_base[HALF_W:2]};
      w_d_nxt = w_rotl ? {w_d_base[HALF_W-1:1], w_d_base[HALF_W]}
                       : {w_d_base[1], w_d_base[HALF_W:2]};
    end else if (w_shift == 2'd2) begin
      w_c_nxt = w_rotl ? {w_c_base[HALF_W-2:1], w_c_base[HALF_W:HALF_W-1]}
                       : {w_c_base[2:1], w_c_base[HALF_W:3]};
      w_d_nxt = w_rotl ? {w_d_base[HALF_W-2:1], w_d_base[HALF_W:HALF_W-1]}
                       : {w_d_base[2:1], w_d_base[HALF_W:3]};
    end else begin
      w_c_nxt = w_c_base;
      w_d_nxt = w_d_base;
    end
  end

  pc2 u_pc2 (
    .i_cd (CD_W'({w_c_nxt, w_d_nxt})),
    .o_sk (w_sk_pc2)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_c     <= '0;
      r_d     <= '0;
      r_sk    <= '0;
      r_round <= '0;
      r_dec   <= DEFAULT_DECRYPT;
    end else begin
      r_state <= w_state_nxt;
      r_c     <= w_c_nxt;
      r_d     <= w_d_nxt;
      r_round <= w_round_nxt;
      r_dec   <= w_dec_nxt;
      if (w_sk_upd) begin
        r_sk <= w_sk_pc2;
      end
    end
  end

  assign key_ready = (r_state == ST_IDLE);
  assign busy      = (r_state == ST_RUN);
  assign sk_valid  = (r_state == ST_RUN);
  assign sk        = r_sk;
  assign sk_round  = r_round;

endmodule

// File: tb/tb_des_subkey_gen.sv
// Randomised self-checking bench for des_subkey_gen against a direct
// FIPS 46-3 key-schedule model (cumulative rotation from C0/D0 per round).
module tb_des_subkey_gen;

  localparam logic [63:0] KEY_REF = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1_REF  = 48'h1B02EFFC7072;
  localparam logic [47:0] K16_REF = 48'hCB3D8B0E17F5;

  localparam int T_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int T_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int T_SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef struct packed {
    logic [47:0] sk;
    logic [3:0]  rnd;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [64:1] key;
  logic        decrypt;
  logic        key_valid;
  logic        key_ready;
  logic [48:1] sk;
  logic [3:0]  sk_round;
  logic        sk_valid;
  logic        sk_ready;
  logic        busy;

  int          n_vec;
  int          n_err;
  exp_t        exp_q [$];
  logic [47:0] got [$];
  logic [47:0] got_a [16];
  logic        m_run;
  logic [47:0] m_last;
  int          cyc;
  int          acc_cyc;
  int          last_hs_cyc;

  des_subkey_gen #(.DEFAULT_DECRYPT(1'b0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key       (key),
    .decrypt   (decrypt),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .sk        (sk),
    .sk_round  (sk_round),
    .sk_valid  (sk_valid),
    .sk_ready  (sk_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Subkey Kn straight from the definition: PC-2 of C0/D0 rotated by sum(s[1..n])
  function automatic logic [47:0] model_sk(input logic [63:0] k, input int n);
    logic [55:0] cd0;
    logic [55:0] cd;
    logic [27:0] c;
    logic [27:0] d;
    logic [47:0] r;
    int          tot;
    for (int i = 0; i < 56; i++) cd0[55-i] = k[64-T_PC1[i]];
    tot = 0;
    for (int j = 0; j < n; j++) tot += T_SH[j];
    tot = tot % 28;
    c = cd0[55:28];
    d = cd0[27:0];
    if (tot != 0) begin
      c = (c << tot) | (c >> (28 - tot));
      d = (d << tot) | (d >> (28 - tot));
    end
    cd = {c, d};
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-T_PC2[i]];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model update at each edge: accept loads 16 expectations, handshake pops one
  initial begin
    m_run = 1'b0; m_last = '0; cyc = 0; acc_cyc = 0; last_hs_cyc = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        m_run  = 1'b0;
        m_last = '0;
      end else begin
        cyc++;
        if (m_run && sk_ready) begin
          m_last = exp_q[0].sk;
          void'(exp_q.pop_front());
          got.push_back(sk);
          last_hs_cyc = cyc;
          if (exp_q.size() == 0) m_run = 1'b0;
        end else if (!m_run && key_valid) begin
          got.delete();
          for (int i = 0; i < 16; i++) begin
            if (decrypt) exp_q.push_back('{sk: model_sk(key, 16 - i), rnd: 4'(15 - i)});
            else         exp_q.push_back('{sk: model_sk(key, i + 1), rnd: 4'(i)});
          end
          m_run   = 1'b1;
          acc_cyc = cyc;
        end
      end
    end
  end

  // Output check on every falling edge
  initial begin
    forever begin
      @(negedge clk);
      chk("sk_valid", 64'(sk_valid), 64'(m_run));
      chk("key_ready", 64'(key_ready), 64'(!m_run));
      chk("busy", 64'(busy), 64'(m_run));
      if (m_run) begin
        chk("sk", 64'(sk), 64'(exp_q[0].sk));
        chk("sk_round", 64'(sk_round), 64'(exp_q[0].rnd));
      end else begin
        chk("sk_idle_hold", 64'(sk), 64'(m_last));
      end
    end
  end

  // One full schedule; mode 0 = ready high, 1 = random ready, 2 = stall 5 cycles at round 7
  task automatic run_key(input logic [63:0] k, input logic dec, input int mode);
    int   n;
    logic bp_done;
    logic [47:0] hold;
    key = k; decrypt = dec; key_valid = 1'b1;
    sk_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    key = {$urandom, $urandom};
    decrypt = ~dec;
    n = 0; bp_done = 1'b0;
    while (m_run && n < 300) begin
      if (mode == 2 && !bp_done && sk_valid && sk_round == 4'd7) begin
        sk_ready = 1'b0;
        hold = sk;
        repeat (5) begin
          @(posedge clk); #1; n++;
          chk("bp_sk", 64'(sk), 64'(hold));
          chk("bp_round", 64'(sk_round), 64'd7);
        end
        sk_ready = 1'b1;
        bp_done  = 1'b1;
      end else if (mode == 1) begin
        sk_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1; n++;
    end
    chk("run_done", 64'(m_run), 64'd0);
    chk("got_count", 64'(got.size()), 64'd16);
    sk_ready = 1'b1;
  endtask

  initial begin
    int n;
    int hs1;
    n_vec = 0; n_err = 0;
    rst_n = 1'b1; key = '0; decrypt = 1'b0; key_valid = 1'b0; sk_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sk", 64'(sk), 64'd0);
    chk("rst_round", 64'(sk_round), 64'd0);
    chk("rst_key_ready", 64'(key_ready), 64'd1);
    rst_n = 1'b1;

    chk("model_k1", 64'(model_sk(KEY_REF, 1)), 64'(K1_REF));
    chk("model_k16", 64'(model_sk(KEY_REF, 16)), 64'(K16_REF));

    // Encrypt reference key, ready held high
    run_key(KEY_REF, 1'b0, 0);
    for (int i = 0; i < 16; i++) got_a[i] = (i < got.size()) ? got[i] : '0;
    chk("enc_first", 64'(got_a[0]), 64'(K1_REF));
    chk("enc_last", 64'(got_a[15]), 64'(K16_REF));
    chk("enc_span", 64'(last_hs_cyc - acc_cyc), 64'd16);

    // Decrypt: reversed encrypt sequence
    run_key(KEY_REF, 1'b1, 0);
    for (int i = 0; i < 16; i++)
      chk("dec_rev", 64'((i < got.size()) ? got[i] : '0), 64'(got_a[15-i]));

    // Backpressure at round 7
    run_key({$urandom, $urandom}, 1'b0, 2);
    run_key({$urandom, $urandom}, 1'b1, 2);

    // Parity bit flipped: identical schedule
    run_key(64'h133457799BBCDFF0, 1'b0, 0);
    for (int i = 0; i < 16; i++)
      chk("parity", 64'((i < got.size()) ? got[i] : '0), 64'(got_a[i]));

    // Reset after 4 handshakes, then a fresh full schedule
    key = {$urandom, $urandom}; decrypt = 1'b0; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    n = 0;
    while (got.size() < 4 && n < 50) begin @(posedge clk); #1; n++; end
    chk("pre_rst_hs", 64'(got.size()), 64'd4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sk", 64'(sk), 64'd0);
    chk("mid_rst_valid", 64'(sk_valid), 64'd0);
    chk("mid_rst_ready", 64'(key_ready), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    run_key({$urandom, $urandom}, 1'b0, 0);

    // Back-to-back: key_valid held high, key and decrypt churn during RUN
    key = {$urandom, $urandom}; decrypt = 1'b0; key_valid = 1'b1;
    @(posedge clk); #1;
    key = {$urandom, $urandom};
    n = 0;
    while (m_run && n < 100) begin
      decrypt = 1'($urandom_range(0, 1));
      @(posedge clk); #1; n++;
    end
    hs1 = last_hs_cyc;
    @(posedge clk); #1;
    key_valid = 1'b0;
    chk("b2b_gap", 64'(acc_cyc - hs1), 64'd1);
    n = 0;
    while (m_run && n < 100) begin @(posedge clk); #1; n++; end
    chk("b2b_done", 64'(m_run), 64'd0);

    // Random keys, directions and ready patterns
    for (int r = 0; r < 8; r++) begin
      run_key({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
